// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and FSM encoding for the pipe issue controller.
package pipe_pkg;
   localparam int N_DEF   = 10;
   localparam int LAT_DEF = 3;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/pipe_res_fifo.sv
// pipe_res_fifo: DEPTH x N show-ahead result FIFO with occupancy count; push never hits a full FIFO.
module pipe_res_fifo #(
   parameter int N     = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [N-1:0]             din,
   input  logic                     pop,
   output logic [N-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [N-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= din;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   assign dout  = mem_q[rd_q];
   assign count = cnt_q;
endmodule

// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: credit-based issue controller for a LAT-stage pipe with result FIFO and drain.
// Optional PIPE_ISSUE_STATS_EN adds saturating issue/stall counters.
module pipe_issue_ctrl
   import pipe_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int LAT   = LAT_DEF,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic [N-1:0] in_c,
   input  logic [N-1:0] in_d,
   output logic [N-1:0] op_a,
   output logic [N-1:0] op_b,
   output logic [N-1:0] op_c,
   output logic [N-1:0] op_d,
   input  logic [N-1:0] pipe_f,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   input  logic         drain_req,
   output logic         drain_done,
   output logic         busy
`ifdef PIPE_ISSUE_STATS_EN
   ,
   output logic [15:0]  issue_cnt,
   output logic [15:0]  stall_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   state_t         state_q, state_d;
   logic [N-1:0]   a_q, b_q, c_q, d_q;
   logic [LAT-1:0] vld_q, vld_d;
   logic [CW-1:0]  occ_q, occ_d;
   logic [AW:0]    fifo_cnt;
   logic           accept, pop;
   // occ counts in-flight ops too, so every accept already owns a FIFO slot
   assign in_ready  = rst_n && state_q != ST_DRAIN && occ_q < CW'(DEPTH);
   assign accept    = in_valid & in_ready;
   assign out_valid = fifo_cnt != '0;
   assign pop       = out_valid & out_ready;
   assign busy      = occ_q != '0 || state_q != ST_IDLE;
   assign op_a      = a_q;
   assign op_b      = b_q;
   assign op_c      = c_q;
   assign op_d      = d_q;
   always_comb begin
      vld_d      = (vld_q << 1) | LAT'(accept);
      occ_d      = occ_q + CW'(accept) - CW'(pop);
      state_d    = state_q;
      drain_done = 1'b0;
      if (state_q != ST_DRAIN && drain_req) state_d = ST_DRAIN;
      else if (state_q == ST_IDLE && accept) state_d = ST_RUN;
      else if (state_q == ST_RUN && occ_q == '0 && !accept) state_d = ST_IDLE;
      else if (state_q == ST_DRAIN && occ_q == '0) begin
         state_d    = ST_IDLE;
         drain_done = rst_n;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vld_q   <= '0;
         occ_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         occ_q   <= occ_d;
         if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
            c_q <= in_c;
            d_q <= in_d;
         end
      end
   end
   pipe_res_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (vld_q[LAT-1]),
      .din   (pipe_f),
      .pop   (pop),
      .dout  (out_data),
      .count (fifo_cnt)
   );
`ifdef PIPE_ISSUE_STATS_EN
   logic [15:0] iss_q, stl_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         iss_q <= '0;
         stl_q <= '0;
      end else begin
         if (accept && iss_q != 16'hFFFF) iss_q <= iss_q + 1'b1;
         if (in_valid && !in_ready && stl_q != 16'hFFFF) stl_q <= stl_q + 1'b1;
      end
   end
   assign issue_cnt = iss_q;
   assign stall_cnt = stl_q;
`endif
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb_pipe_issue_ctrl: directed bench for pipe_issue_ctrl; pipe stubbed as LAT-stage delay of a+b+c+d.
module tb_pipe_issue_ctrl;
   localparam int N = 10;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0, in_ready;
   logic [N-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
   logic [N-1:0] op_a, op_b, op_c, op_d, pipe_f, out_data;
   logic         out_valid, out_ready = 1'b0, drain_req = 1'b0, drain_done, busy;
   logic [N-1:0] s1_q, s2_q;
   int           n_cmp = 0, n_bad = 0;
`ifdef PIPE_ISSUE_STATS_EN
   logic [15:0]  issue_cnt, stall_cnt;
   logic [15:0]  iss0, stl0;
`endif

   always #5 clk = ~clk;

   // op regs form stage 1, two more stages give LAT=3
   always_ff @(posedge clk) begin
      s1_q <= N'(op_a + op_b + op_c + op_d);
      s2_q <= s1_q;
   end
   assign pipe_f = s2_q;

   pipe_issue_ctrl #(.N(N), .LAT(3), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
      .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d), .pipe_f(pipe_f),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .drain_req(drain_req), .drain_done(drain_done), .busy(busy)
`ifdef PIPE_ISSUE_STATS_EN
      , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input int a, input int b, input int c, input int d);
      in_valid = iv;
      in_a = N'(a);
      in_b = N'(b);
      in_c = N'(c);
      in_d = N'(d);
   endtask

   typedef struct {
      logic iv;
      int   a, b, c, d;
      logic e_rdy, e_ov;
      int   e_od;
      logic e_busy;
   } vec_t;
   vec_t tv[9];
   int   exp_q[$];
   int   dd_cnt;

   initial begin
      tv[0] = '{1'b1, 10, 12, 6, 3, 1'b1, 1'b0,  0, 1'b0};
      tv[1] = '{1'b1, 10, 10, 5, 3, 1'b1, 1'b0,  0, 1'b1};
      tv[2] = '{1'b1, 20, 11, 1, 4, 1'b1, 1'b0,  0, 1'b1};
      tv[3] = '{1'b0,  0,  0, 0, 0, 1'b1, 1'b0,  0, 1'b1};
      tv[4] = '{1'b0,  0,  0, 0, 0, 1'b1, 1'b1, 31, 1'b1};
      tv[5] = '{1'b0,  0,  0, 0, 0, 1'b1, 1'b1, 28, 1'b1};
      tv[6] = '{1'b0,  0,  0, 0, 0, 1'b1, 1'b1, 36, 1'b1};
      tv[7] = '{1'b0,  0,  0, 0, 0, 1'b1, 1'b0,  0, 1'b1};
      tv[8] = '{1'b0,  0,  0, 0, 0, 1'b1, 1'b0,  0, 1'b0};

      // reset held for 3 cycles
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ops", {op_a, op_b, op_c}, 0);
      chk("rst_op_d", op_d, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 1);
      chk("rel_busy", busy, 0);
      chk("rel_drain_done", drain_done, 0);

      // back-to-back stream, consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive(tv[i].iv, tv[i].a, tv[i].b, tv[i].c, tv[i].d);
         #1;
         chk($sformatf("s2_rdy[%0d]", i), in_ready, tv[i].e_rdy);
         chk($sformatf("s2_ov[%0d]", i), out_valid, tv[i].e_ov);
         chk($sformatf("s2_busy[%0d]", i), busy, tv[i].e_busy);
         if (tv[i].e_ov) chk($sformatf("s2_od[%0d]", i), out_data, tv[i].e_od);
      end

      // backpressure: credits run out after exactly DEPTH accepts
`ifdef PIPE_ISSUE_STATS_EN
      iss0 = issue_cnt;
      stl0 = stall_cnt;
`endif
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(1'b1, i + 1, 2 * i, 7, 100);
         if (i < 4) exp_q.push_back(3 * i + 108);
         #1;
         chk($sformatf("s3_rdy[%0d]", i), in_ready, i < 4);
      end
      @(negedge clk);
      drive(1'b0, 0, 0, 0, 0);
      out_ready = 1'b1;
      #1;
`ifdef PIPE_ISSUE_STATS_EN
      chk("s6_issue", issue_cnt - iss0, 4);
      chk("s6_stall", stall_cnt - stl0, 4);
`endif
      chk("s3_rdy_full", in_ready, 0);
      for (int j = 0; j < 4; j++) begin
         if (j > 0) begin
            @(negedge clk);
            #1;
            chk($sformatf("s3_rdy_back[%0d]", j), in_ready, 1);
         end
         chk($sformatf("s3_ov[%0d]", j), out_valid, 1);
         chk($sformatf("s3_od[%0d]", j), out_data, exp_q[j]);
      end
      @(negedge clk);
      #1;
      chk("s3_empty", out_valid, 0);

      // drain with two ops in flight
      exp_q.delete();
      dd_cnt = 0;
      @(negedge clk);
      drive(1'b1, 1, 1, 1, 1);
      #1;
      chk("s4_rdy0", in_ready, 1);
      @(negedge clk);
      drive(1'b1, 50, 60, 70, 80);
      #1;
      chk("s4_rdy1", in_ready, 1);
      @(negedge clk);
      drive(1'b0, 0, 0, 0, 0);
      drain_req = 1'b1;
      #1;
      dd_cnt += int'(drain_done);
      for (int i = 3; i < 7; i++) begin
         @(negedge clk);
         drive(1'b1, 300, 1, 1, 1);
         drain_req = 1'b0;
         #1;
         dd_cnt += int'(drain_done);
         chk($sformatf("s4_rdy[%0d]", i), in_ready, 0);
         chk($sformatf("s4_ov[%0d]", i), out_valid, i == 4 || i == 5);
         if (i == 4) chk("s4_od0", out_data, 4);
         if (i == 5) chk("s4_od1", out_data, 260);
         if (i == 6) chk("s4_done", drain_done, 1);
      end
      @(negedge clk);
      drive(1'b0, 0, 0, 0, 0);
      #1;
      dd_cnt += int'(drain_done);
      chk("s4_rdy_after", in_ready, 1);
      chk("s4_done_once", dd_cnt, 1);

      // reset with three ops in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, i + 5, 0, 0, 1);
         #1;
         chk($sformatf("s5_rdy[%0d]", i), in_ready, 1);
      end
      @(negedge clk);
      drive(1'b0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("s5_rdy_rst", in_ready, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rst_n = 1'b1;
         #1;
         chk($sformatf("s5_ov[%0d]", i), out_valid, 0);
         if (i == 0) begin
            chk("s5_busy", busy, 0);
            chk("s5_op_a", op_a, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
